// File: rtl/debouncer_pkg.sv
// Shared defaults and latency helper for the multi-channel debouncer.
package debouncer_pkg;
  localparam int DEB_CNT_W_DEFAULT = 3;
  localparam int DEB_SYNC_DEFAULT  = 2;

  // Edge (counted from the first sampling edge) at which a clean step commits.
  function automatic int deb_latency(input int sync, input int thr);
    return sync + thr + 1;
  endfunction
endpackage

// File: rtl/debouncer_chan.sv
// One debouncer channel: synchroniser chain, stability counter, registered rise/fall pulses.
// o_commit exists only when DEBOUNCER_EVENT_LATCH_EN is defined.
module debouncer_chan import debouncer_pkg::*; #(
  parameter int   CNT_W       = DEB_CNT_W_DEFAULT,
  parameter int   SYNC_STAGES = DEB_SYNC_DEFAULT,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in,
  input  logic [CNT_W-1:0] i_thresh,
`ifdef DEBOUNCER_EVENT_LATCH_EN
  output logic             o_commit,
`endif
  output logic             o_out,
  output logic             o_rise,
  output logic             o_fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   out_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   s;
  logic                   commit;

  if (deb_latency(SYNC_STAGES, 0) < deb_latency(2, 0)) begin : g_bad_sync
    $error("debouncer_chan: SYNC_STAGES must be at least 2");
  end

  assign s = sync_q[SYNC_STAGES-1];
  // >= rather than == so a threshold lowered below the running count still commits.
  assign commit = (s != out_q) && (cnt_q >= i_thresh);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      cnt_q  <= '0;
      out_q  <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_in};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (s == out_q) begin
        cnt_q <= '0;
      end else if (!commit) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        out_q  <= s;
        cnt_q  <= '0;
        rise_q <= s;
        fall_q <= ~s;
      end
    end
  end

  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(rise_q && fall_q));

`ifdef DEBOUNCER_EVENT_LATCH_EN
  assign o_commit = commit;
`endif
  assign o_out  = out_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;
endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: fans out CHANNELS independent debouncer_chan instances.
// DEBOUNCER_EVENT_LATCH_EN adds a sticky per-channel commit flag with clear input.
module debouncer_multi import debouncer_pkg::*; #(
  parameter int   CHANNELS    = 4,
  parameter int   CNT_W       = DEB_CNT_W_DEFAULT,
  parameter int   SYNC_STAGES = DEB_SYNC_DEFAULT,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_in,
  input  logic [CNT_W-1:0]    i_thresh,
`ifdef DEBOUNCER_EVENT_LATCH_EN
  input  logic [CHANNELS-1:0] i_evt_clr,
  output logic [CHANNELS-1:0] o_evt,
`endif
  output logic [CHANNELS-1:0] o_out,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall
);
`ifdef DEBOUNCER_EVENT_LATCH_EN
  logic [CHANNELS-1:0] commit;
  logic [CHANNELS-1:0] evt_q;
`endif

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    debouncer_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (RESET_VAL)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_in     (i_in[n]),
      .i_thresh (i_thresh),
`ifdef DEBOUNCER_EVENT_LATCH_EN
      .o_commit (commit[n]),
`endif
      .o_out    (o_out[n]),
      .o_rise   (o_rise[n]),
      .o_fall   (o_fall[n])
    );
  end

`ifdef DEBOUNCER_EVENT_LATCH_EN
  // A commit on the same edge as a clear leaves the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= (evt_q & ~i_evt_clr) | commit;
    end
  end

  assign o_evt = evt_q;
`endif
endmodule

// File: tb/tb_debouncer_multi.sv
// Directed testbench for debouncer_multi (CHANNELS=4, CNT_W=3, SYNC_STAGES=2, RESET_VAL=0).
module tb_debouncer_multi;
  import debouncer_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [3:0] i_in;
  logic [2:0] i_thresh;
  logic [3:0] o_out;
  logic [3:0] o_rise;
  logic [3:0] o_fall;
`ifdef DEBOUNCER_EVENT_LATCH_EN
  logic [3:0] i_evt_clr;
  logic [3:0] o_evt;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [3:0] pulse_acc;

  debouncer_multi #(
    .CHANNELS    (4),
    .CNT_W       (3),
    .SYNC_STAGES (2),
    .RESET_VAL   (1'b0)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_in     (i_in),
    .i_thresh (i_thresh),
`ifdef DEBOUNCER_EVENT_LATCH_EN
    .i_evt_clr(i_evt_clr),
    .o_evt    (o_evt),
`endif
    .o_out    (o_out),
    .o_rise   (o_rise),
    .o_fall   (o_fall)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
      pulse_acc = pulse_acc | o_rise | o_fall;
    end
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_in      = 4'hF;
    i_thresh  = 3'd7;
    pulse_acc = '0;
`ifdef DEBOUNCER_EVENT_LATCH_EN
    i_evt_clr = '0;
`endif

    // 1: reset state, then quiet release
    tick(3);
    check("rst_out", {28'd0, o_out}, 32'h0);
    check("rst_rise", {28'd0, o_rise}, 32'h0);
    check("rst_fall", {28'd0, o_fall}, 32'h0);
    i_in      = 4'h0;
    i_rst_n   = 1'b1;
    pulse_acc = '0;
    tick(12);
    check("idle_out", {28'd0, o_out}, 32'h0);
    check("idle_pulse", {28'd0, pulse_acc}, 32'h0);

    // 2: short toggles on channel 0 never commit
    i_in[0] = 1'b1; tick(1);
    i_in[0] = 1'b0; tick(1);
    i_in[0] = 1'b1; tick(1);
    i_in[0] = 1'b0; tick(12);
    check("glitch_out", {28'd0, o_out}, 32'h0);
    check("glitch_pulse", {28'd0, pulse_acc}, 32'h0);

    // 3: clean rise on channel 1, commit at edge 10
    i_in[1] = 1'b1;
    tick(deb_latency(2, 7) - 1);
    check("rise_early", {28'd0, o_out}, 32'h0);
    tick(1);
    check("rise_out", {28'd0, o_out}, 32'h2);
    check("rise_pulse", {28'd0, o_rise}, 32'h2);
    check("rise_nofall", {28'd0, o_fall}, 32'h0);
    tick(1);
    check("rise_once", {28'd0, o_rise}, 32'h0);
    check("rise_hold", {28'd0, o_out}, 32'h2);

    // 4: 5-cycle dip ignored, then long low commits a fall
    pulse_acc = '0;
    i_in[1] = 1'b0; tick(5);
    i_in[1] = 1'b1; tick(12);
    check("dip_out", {28'd0, o_out}, 32'h2);
    check("dip_pulse", {28'd0, pulse_acc}, 32'h0);
    i_in[1] = 1'b0;
    tick(9);
    check("fall_early", {28'd0, o_out}, 32'h2);
    tick(1);
    check("fall_out", {28'd0, o_out}, 32'h0);
    check("fall_pulse", {28'd0, o_fall}, 32'h2);
    check("fall_norise", {28'd0, o_rise}, 32'h0);
    tick(1);
    check("fall_once", {28'd0, o_fall}, 32'h0);

    // 5a: threshold 0 on channel 2 commits at edge 3
    i_thresh = 3'd0;
    i_in[2]  = 1'b1;
    tick(2);
    check("thr0_early", {28'd0, o_out}, 32'h0);
    tick(1);
    check("thr0_out", {28'd0, o_out}, 32'h4);
    check("thr0_rise", {28'd0, o_rise}, 32'h4);

    // 5b: channel 3 counts to 5 at thr=7, thr lowered to 2 commits next edge
    i_thresh = 3'd7;
    i_in[3]  = 1'b1;
    tick(7);
    check("thrdn_early", {28'd0, o_out}, 32'h4);
    i_thresh = 3'd2;
    tick(1);
    check("thrdn_out", {28'd0, o_out}, 32'hC);
    check("thrdn_rise", {28'd0, o_rise}, 32'h8);
    i_thresh = 3'd7;

    // 6: reset while channel 0 holds cnt=6
    i_in[0] = 1'b1;
    tick(8);
    check("prerst_out", {28'd0, o_out}, 32'hC);
    i_rst_n = 1'b0;
    #1;
    check("asyncrst_out", {28'd0, o_out}, 32'h0);
    check("asyncrst_pulse", {28'd0, o_rise | o_fall}, 32'h0);
    i_in = 4'h0;
    tick(2);
    pulse_acc = '0;
    i_rst_n   = 1'b1;
    tick(12);
    check("postrst_out", {28'd0, o_out}, 32'h0);
    check("postrst_pulse", {28'd0, pulse_acc}, 32'h0);

`ifdef DEBOUNCER_EVENT_LATCH_EN
    // event latch: commit coincident with clear keeps the flag set
    check("evt_rst", {28'd0, o_evt}, 32'h0);
    i_evt_clr = 4'hF;
    i_thresh  = 3'd0;
    i_in[0]   = 1'b1;
    tick(3);
    check("evt_commit_out", {28'd0, o_out}, 32'h1);
    check("evt_set_wins", {28'd0, o_evt}, 32'h1);
    tick(1);
    check("evt_cleared", {28'd0, o_evt}, 32'h0);
    i_evt_clr = 4'h0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
